pick_controller: RTL and testbench



---
 rtl/pick_controller.sv | 156 +++++++++++++++
 tb/tb_pick_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pick_controller.sv
// Lock-pick game controller: slot navigation, pick insert/attempt/retract
// motion paced by frame_tick, and attempt bookkeeping. All outputs registered.
module pick_controller (
    input  logic       Clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       levelDone,
    input  logic       close,
    output logic [9:0] pickY,
    output logic [9:0] pickLRx,
    output logic       openner,
    output logic [4:0] slot,
    output logic [2:0] attempts,
    output logic       closeHint,
    output logic       success
);

    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam logic [9:0] LRX_OUT = 10'd560;
    localparam logic [9:0] LRX_IN  = 10'd500;
    localparam logic [9:0] LRX_STEP = 10'd4;

    typedef enum logic [2:0] {
        IDLE,
        INSERT,
        ATTEMPT,
        RETRACT,
        SUCCESS
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  prev_key_reg;
    logic [4:0]  slot_reg, slot_next;
    logic [9:0]  pick_y_reg, pick_y_next;
    logic [9:0]  lrx_reg, lrx_next;
    logic        openner_reg, openner_next;
    logic [2:0]  attempts_reg, attempts_next;
    logic        close_hint_reg, close_hint_next;
    logic        success_reg, success_next;
    logic [3:0]  tick_cnt_reg, tick_cnt_next;

    logic press_up, press_down, press_space;

    // A press is the first cycle a keycode appears; holding a key does nothing more.
    assign press_up    = (keycode == KEY_UP)    && (prev_key_reg != KEY_UP);
    assign press_down  = (keycode == KEY_DOWN)  && (prev_key_reg != KEY_DOWN);
    assign press_space = (keycode == KEY_SPACE) && (prev_key_reg != KEY_SPACE);

    always_comb begin
        state_next      = state_reg;
        slot_next       = slot_reg;
        lrx_next        = lrx_reg;
        attempts_next   = attempts_reg;
        close_hint_next = close_hint_reg;
        tick_cnt_next   = tick_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (press_up && slot_reg != 5'd0) begin
                    slot_next = slot_reg - 5'd1;
                end else if (press_down && slot_reg != 5'd31) begin
                    slot_next = slot_reg + 5'd1;
                end
                if (press_space && attempts_reg != 3'd7) begin
                    state_next      = INSERT;
                    close_hint_next = 1'b0;
                end
            end
            INSERT: begin
                if (frame_tick) begin
                    lrx_next = lrx_reg - LRX_STEP;
                    if (lrx_reg == LRX_IN + LRX_STEP) begin
                        state_next    = ATTEMPT;
                        tick_cnt_next = 4'd0;
                    end
                end
            end
            ATTEMPT: begin
                if (close) begin
                    close_hint_next = 1'b1;
                end
                // A solved lock wins over the attempt timing out in the same cycle.
                if (levelDone) begin
                    state_next = SUCCESS;
                end else if (frame_tick) begin
                    if (tick_cnt_reg == 4'd7) begin
                        state_next    = RETRACT;
                        tick_cnt_next = 4'd0;
                        if (attempts_reg != 3'd7) begin
                            attempts_next = attempts_reg + 3'd1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 4'd1;
                    end
                end
            end
            RETRACT: begin
                if (frame_tick) begin
                    lrx_next = lrx_reg + LRX_STEP;
                    if (lrx_reg == LRX_OUT - LRX_STEP) begin
                        state_next = IDLE;
                    end
                end
            end
            SUCCESS: begin
                lrx_next = LRX_IN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        openner_next = !((state_next == ATTEMPT) || (state_next == SUCCESS));
        success_next = (state_next == SUCCESS);
        pick_y_next  = 10'd40 + 10'd14 * 10'(slot_reg);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            prev_key_reg   <= 8'h00;
            slot_reg       <= 5'd15;
            pick_y_reg     <= 10'd250;
            lrx_reg        <= LRX_OUT;
            openner_reg    <= 1'b1;
            attempts_reg   <= 3'd0;
            close_hint_reg <= 1'b0;
            success_reg    <= 1'b0;
            tick_cnt_reg   <= 4'd0;
        end else begin
            state_reg      <= state_next;
            prev_key_reg   <= keycode;
            slot_reg       <= slot_next;
            pick_y_reg     <= pick_y_next;
            lrx_reg        <= lrx_next;
            openner_reg    <= openner_next;
            attempts_reg   <= attempts_next;
            close_hint_reg <= close_hint_next;
            success_reg    <= success_next;
            tick_cnt_reg   <= tick_cnt_next;
        end
    end

    assign pickY     = pick_y_reg;
    assign pickLRx   = lrx_reg;
    assign openner   = openner_reg;
    assign slot      = slot_reg;
    assign attempts  = attempts_reg;
    assign closeHint = close_hint_reg;
    assign success   = success_reg;

endmodule

// File: tb/tb_pick_controller.sv
// Scoreboard bench for pick_controller: expectations are queued as stimulus is
// driven and popped against the registered outputs once the stimulus has settled.
module tb_pick_controller;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       levelDone = 1'b0;
    logic       close = 1'b0;
    logic [9:0] pickY, pickLRx;
    logic       openner;
    logic [4:0] slot;
    logic [2:0] attempts;
    logic       closeHint, success;

    pick_controller dut (
        .Clk        (Clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .keycode    (keycode),
        .levelDone  (levelDone),
        .close      (close),
        .pickY      (pickY),
        .pickLRx    (pickLRx),
        .openner    (openner),
        .slot       (slot),
        .attempts   (attempts),
        .closeHint  (closeHint),
        .success    (success)
    );

    always #5 Clk = ~Clk;

    localparam int SEL_Y = 0, SEL_LRX = 1, SEL_OPN = 2, SEL_SLOT = 3;
    localparam int SEL_ATT = 4, SEL_HINT = 5, SEL_SUC = 6;

    typedef struct {
        string tag;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_att = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            SEL_Y:    return int'(pickY);
            SEL_LRX:  return int'(pickLRx);
            SEL_OPN:  return int'(openner);
            SEL_SLOT: return int'(slot);
            SEL_ATT:  return int'(attempts);
            SEL_HINT: return int'(closeHint);
            default:  return int'(success);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain(input string txn);
        exp_t e;
        int n;
        n = sb.size();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val({txn, ".", e.tag}, observe(e.sel), e.exp);
        end
        $display("[%0t] %s: %0d checks, slot=%0d y=%0d lrx=%0d opn=%0d att=%0d hint=%0d suc=%0d",
                 $time, txn, n, slot, pickY, pickLRx, openner, attempts, closeHint, success);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        step();
        keycode = 8'h00;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic push_reset_values();
        push("y", SEL_Y, 250);
        push("lrx", SEL_LRX, 560);
        push("opn", SEL_OPN, 1);
        push("slot", SEL_SLOT, 15);
        push("att", SEL_ATT, 0);
        push("hint", SEL_HINT, 0);
        push("suc", SEL_SUC, 0);
    endtask

    // One complete failed attempt; close is pulsed between ticks when requested.
    task automatic failed_attempt(input string name, input bit with_close);
        press(8'h2C);
        push("hint_cleared", SEL_HINT, 0);
        push("lrx_still_out", SEL_LRX, 560);
        drain({name, "_space"});
        ticks(14);
        push("lrx_504", SEL_LRX, 504);
        push("opn_idle", SEL_OPN, 1);
        drain({name, "_tick14"});
        ticks(1);
        push("lrx_500", SEL_LRX, 500);
        push("opn_low", SEL_OPN, 0);
        drain({name, "_inserted"});
        ticks(3);
        if (with_close) begin
            close = 1'b1;
            step();
            close = 1'b0;
        end
        ticks(4);
        push("opn_still_low", SEL_OPN, 0);
        push("att_before", SEL_ATT, exp_att);
        drain({name, "_tick7"});
        ticks(1);
        exp_att = (exp_att < 7) ? exp_att + 1 : 7;
        push("opn_released", SEL_OPN, 1);
        push("att", SEL_ATT, exp_att);
        push("hint", SEL_HINT, with_close ? 1 : 0);
        drain({name, "_expired"});
        ticks(15);
        push("lrx_560", SEL_LRX, 560);
        drain({name, "_retracted"});
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        push_reset_values();
        drain("reset");

        // Navigation with saturation at both ends
        for (int i = 0; i < 20; i++) press(8'h52);
        push("slot", SEL_SLOT, 0);
        push("y", SEL_Y, 40);
        drain("up_x20");
        for (int i = 0; i < 40; i++) press(8'h51);
        push("slot", SEL_SLOT, 31);
        push("y", SEL_Y, 474);
        drain("down_x40");

        // Held key increments once
        reset = 1'b1;
        step();
        reset = 1'b0;
        keycode = 8'h51;
        for (int i = 0; i < 100; i++) step();
        keycode = 8'h00;
        step();
        push("slot", SEL_SLOT, 16);
        push("y", SEL_Y, 264);
        drain("held_down");

        // Key applied when a tick lands in the same IDLE cycle; tick itself ignored
        keycode = 8'h51;
        frame_tick = 1'b1;
        step();
        keycode = 8'h00;
        frame_tick = 1'b0;
        step();
        push("slot", SEL_SLOT, 17);
        push("y", SEL_Y, 278);
        push("lrx", SEL_LRX, 560);
        drain("key_with_tick");

        failed_attempt("attempt1", 1'b1);
        press(8'h51);
        push("slot_after_return", SEL_SLOT, 18);
        drain("idle_again");

        // Navigation ignored outside IDLE
        press(8'h2C);
        ticks(5);
        press(8'h52);
        press(8'h2C);
        push("slot_held", SEL_SLOT, 18);
        push("hint_cleared", SEL_HINT, 0);
        push("lrx_moving", SEL_LRX, 540);
        drain("keys_in_insert");
        ticks(10);
        ticks(8);
        exp_att++;
        ticks(15);
        push("att", SEL_ATT, exp_att);
        push("lrx", SEL_LRX, 560);
        drain("attempt2");

        for (int a = 3; a <= 7; a++) failed_attempt($sformatf("attempt%0d", a), 1'b0);
        push("att_max", SEL_ATT, 7);
        drain("lockout_reached");
        press(8'h2C);
        ticks(15);
        push("lrx", SEL_LRX, 560);
        push("opn", SEL_OPN, 1);
        push("att", SEL_ATT, 7);
        drain("lockout_space");

        // Reset mid-attempt, with a tick in the same cycle
        reset = 1'b1;
        step();
        reset = 1'b0;
        press(8'h2C);
        ticks(15);
        ticks(3);
        push("opn_low", SEL_OPN, 0);
        drain("attempt_tick3");
        reset = 1'b1;
        frame_tick = 1'b1;
        keycode = 8'h52;
        step();
        push_reset_values();
        drain("reset_mid_attempt");
        reset = 1'b0;
        frame_tick = 1'b0;
        keycode = 8'h00;
        step();

        // Success is terminal
        press(8'h51);
        press(8'h2C);
        ticks(15);
        ticks(2);
        levelDone = 1'b1;
        step();
        levelDone = 1'b0;
        push("suc", SEL_SUC, 1);
        push("opn", SEL_OPN, 0);
        push("lrx", SEL_LRX, 500);
        drain("success");
        press(8'h52);
        press(8'h2C);
        ticks(20);
        push("suc", SEL_SUC, 1);
        push("opn", SEL_OPN, 0);
        push("lrx", SEL_LRX, 500);
        push("slot", SEL_SLOT, 16);
        push("y", SEL_Y, 264);
        push("att", SEL_ATT, 0);
        drain("success_frozen");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
